interleaver_block_ctrl: RTL and testbench



---
 rtl/intlv_pkg.sv | 30 +++
 rtl/interleaver_block_ctrl_if.sv | 42 ++++
 rtl/intlv_stream_cnt.sv | 54 +++++
 rtl/interleaver_block_ctrl.sv | 110 +++++++++++
 tb/tb_interleaver_block_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intlv_pkg.sv
// rtl/intlv_pkg.sv - shared constants, state enums and size helpers for the interleaver controller
// Block sizes in bits and in bytes for the two supported turbo block lengths.
package intlv_pkg;

   localparam int K_SMALL  = 1056;
   localparam int K_LARGE  = 6144;
   localparam int NB_SMALL = 132;
   localparam int NB_LARGE = 768;

   typedef enum logic [1:0] {
      F_IDLE = 2'd0,
      F_FILL = 2'd1,
      F_FULL = 2'd2
   } fill_state_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } stream_state_t;

   function automatic logic [13:0] k_last(input logic k6144);
      return k6144 ? 14'(K_LARGE - 1) : 14'(K_SMALL - 1);
   endfunction

   // Counter value held while the final byte of a block is being accepted.
   function automatic logic [9:0] nb_last(input logic k6144);
      return k6144 ? 10'(NB_LARGE - 1) : 10'(NB_SMALL - 1);
   endfunction

endpackage

// File: rtl/interleaver_block_ctrl_if.sv
// rtl/interleaver_block_ctrl_if.sv - byte-in / bit-index-out signal bundle of the interleaver controller
// drop_err exists only when INTLV_CTRL_DROP_DETECT_EN is defined.
interface interleaver_block_ctrl_if #(
   parameter int IDX_W = 14
);

   logic             in_valid;
   logic [7:0]       in_byte;
   logic             in_k6144;
   logic             in_ready;
   logic             shift_en;
   logic [7:0]       byte_out;
   logic             load_en;
   logic             k_size_6144;
   logic             out_stall;
   logic [IDX_W-1:0] mux_ind;
   logic             out_valid;
   logic             out_first;
   logic             out_last;
`ifdef INTLV_CTRL_DROP_DETECT_EN
   logic             drop_err;
`endif

   modport slave (
      input  in_valid, in_byte, in_k6144, out_stall,
      output in_ready, shift_en, byte_out, load_en, k_size_6144,
             mux_ind, out_valid, out_first, out_last
`ifdef INTLV_CTRL_DROP_DETECT_EN
      , output drop_err
`endif
   );

   modport master (
      output in_valid, in_byte, in_k6144, out_stall,
      input  in_ready, shift_en, byte_out, load_en, k_size_6144,
             mux_ind, out_valid, out_first, out_last
`ifdef INTLV_CTRL_DROP_DETECT_EN
      , input drop_err
`endif
   );

endinterface

// File: rtl/intlv_stream_cnt.sv
// rtl/intlv_stream_cnt.sv - stream FSM and K-cycle bit index for the ci/cpii mux pair
// A load always restarts the index at 0, so a load on the last bit wraps with no idle cycle.
module intlv_stream_cnt
   import intlv_pkg::*;
#(
   parameter int IDX_W = 14
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             load_i,
   input  logic             stall_i,
   input  logic             k_i,
   output logic [IDX_W-1:0] mux_ind_o,
   output logic             k_o,
   output logic             valid_o,
   output logic             first_o,
   output logic             last_o
);

   stream_state_t    state_q;
   logic [IDX_W-1:0] ind_q;
   logic [IDX_W-1:0] ind_d;
   logic             k_q;
   logic             at_last;

   assign ind_d   = ind_q + IDX_W'(1);
   assign at_last = (state_q == S_RUN) && (ind_q == IDX_W'(k_last(k_q)));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ind_q   <= '0;
         k_q     <= 1'b0;
      end else if (load_i) begin
         state_q <= S_RUN;
         ind_q   <= '0;
         k_q     <= k_i;
      end else if ((state_q == S_RUN) && !stall_i) begin
         if (at_last) begin
            state_q <= S_IDLE;
            ind_q   <= '0;
         end else begin
            ind_q   <= ind_d;
         end
      end
   end

   assign mux_ind_o = ind_q;
   assign k_o       = k_q;
   assign valid_o   = (state_q == S_RUN);
   assign first_o   = (state_q == S_RUN) && (ind_q == '0);
   assign last_o    = at_last;

endmodule

// File: rtl/interleaver_block_ctrl.sv
// rtl/interleaver_block_ctrl.sv - byte fill FSM, buffer load scheduling and stream sequencing
// Optional INTLV_CTRL_DROP_DETECT_EN adds a sticky drop_err for bytes offered while not ready.
module interleaver_block_ctrl
   import intlv_pkg::*;
#(
   parameter int IDX_W = 14,
   parameter int CNT_W = 10
) (
   input  logic                      clock,
   input  logic                      rst,
   interleaver_block_ctrl_if.slave   bus
);

   fill_state_t      fill_q;
   logic             fill_k_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [CNT_W-1:0] byte_cnt_d;

   logic             accept;
   logic             load;
   logic             stream_valid;
   logic             stream_last;
   logic             stream_k;
   logic [IDX_W-1:0] stream_ind;
   logic             stream_first;

   assign bus.in_ready = !rst && (fill_q != F_FULL);
   assign accept       = bus.in_valid && bus.in_ready;
   assign byte_cnt_d   = byte_cnt_q + CNT_W'(1);

   // A full buffer is handed over either to an idle stream or exactly on the
   // unstalled last bit, which is what keeps back-to-back blocks gap-free.
   assign load = (fill_q == F_FULL) &&
                 (!stream_valid || (stream_last && !bus.out_stall));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         fill_q     <= F_IDLE;
         fill_k_q   <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         case (fill_q)
            F_IDLE: begin
               if (accept) begin
                  fill_k_q   <= bus.in_k6144;
                  byte_cnt_q <= CNT_W'(1);
                  fill_q     <= F_FILL;
               end
            end
            F_FILL: begin
               if (accept) begin
                  if (byte_cnt_q == CNT_W'(nb_last(fill_k_q))) begin
                     byte_cnt_q <= '0;
                     fill_q     <= F_FULL;
                  end else begin
                     byte_cnt_q <= byte_cnt_d;
                  end
               end
            end
            F_FULL: begin
               if (load) begin
                  fill_q <= F_IDLE;
               end
            end
            default: begin
               fill_q <= F_IDLE;
            end
         endcase
      end
   end

   intlv_stream_cnt #(
      .IDX_W (IDX_W)
   ) u_stream (
      .clock     (clock),
      .rst       (rst),
      .load_i    (load),
      .stall_i   (bus.out_stall),
      .k_i       (fill_k_q),
      .mux_ind_o (stream_ind),
      .k_o       (stream_k),
      .valid_o   (stream_valid),
      .first_o   (stream_first),
      .last_o    (stream_last)
   );

   assign bus.shift_en    = accept;
   assign bus.byte_out    = accept ? bus.in_byte : 8'h00;
   assign bus.load_en     = load;
   assign bus.k_size_6144 = stream_k;
   assign bus.mux_ind     = stream_ind;
   assign bus.out_valid   = stream_valid;
   assign bus.out_first   = stream_first;
   assign bus.out_last    = stream_last;

`ifdef INTLV_CTRL_DROP_DETECT_EN
   logic drop_q;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         drop_q <= 1'b0;
      end else if (bus.in_valid && !bus.in_ready) begin
         drop_q <= 1'b1;
      end
   end

   assign bus.drop_err = drop_q;
`endif

endmodule

// File: tb/tb_interleaver_block_ctrl.sv
// tb/tb_interleaver_block_ctrl.sv - randomized scoreboard bench for interleaver_block_ctrl
// Completed blocks are queued with their finish cycle; the monitor derives each block's start.
module tb_interleaver_block_ctrl;

   logic clock = 1'b0;
   logic rst;

   always #5 clock = ~clock;

   interleaver_block_ctrl_if #(.IDX_W(14)) bus ();

   interleaver_block_ctrl #(
      .IDX_W (14),
      .CNT_W (10)
   ) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   typedef struct {
      bit k;
      int t_done;
   } blk_t;

   blk_t sb[$];

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit active   = 1'b0;
   int pos      = 0;
   bit exp_k    = 1'b0;
   int prev_end = -10;
   bit exp_drop = 1'b0;
   bit pend_full;
   bit exp_ready;
   bit exp_shift;
   bit exp_load;
   int cur_len;

   bit stall_armed = 1'b0;
   int stall_at    = 0;
   int stall_left  = 0;
   bit rnd_stall   = 1'b0;

   function automatic int klen(input bit k);
      return k ? 6144 : 1056;
   endfunction

   function automatic int nbytes(input bit k);
      return k ? 768 : 132;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Downstream consumer: a one-shot 5-cycle stall at a chosen index, plus optional random stalls.
   initial begin
      bus.out_stall = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (stall_left > 0) begin
            bus.out_stall = 1'b1;
            stall_left--;
         end else if (stall_armed && bus.out_valid && (int'(bus.mux_ind) == stall_at)) begin
            stall_armed   = 1'b0;
            bus.out_stall = 1'b1;
            stall_left    = 4;
         end else begin
            bus.out_stall = rnd_stall && ($urandom_range(0, 7) == 0);
         end
      end
   end

   // Monitor: a block starts no earlier than 2 cycles after its last byte and 1 cycle after the previous block ends.
   always @(negedge clock) begin
      if (rst) begin
         chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
         chk("rst_shift_en", 32'(bus.shift_en), 32'(0));
         chk("rst_load_en", 32'(bus.load_en), 32'(0));
         chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
         chk("rst_mux_ind", 32'(bus.mux_ind), 32'(0));
         chk("rst_k_size", 32'(bus.k_size_6144), 32'(0));
         chk("rst_byte_out", 32'(bus.byte_out), 32'(0));
         chk("rst_first_last", 32'({bus.out_first, bus.out_last}), 32'(0));
`ifdef INTLV_CTRL_DROP_DETECT_EN
         chk("rst_drop_err", 32'(bus.drop_err), 32'(0));
`endif
         sb.delete();
         active   = 1'b0;
         pos      = 0;
         exp_k    = 1'b0;
         prev_end = -10;
         exp_drop = 1'b0;
      end else begin
         if (!active && (sb.size() > 0) && (cyc >= sb[0].t_done + 2) && (cyc >= prev_end + 1)) begin
            exp_k  = sb[0].k;
            void'(sb.pop_front());
            active = 1'b1;
            pos    = 0;
         end
         pend_full = (sb.size() > 0) && (sb[0].t_done < cyc);
         exp_ready = !pend_full;
         exp_shift = bus.in_valid && exp_ready;
         cur_len   = klen(exp_k);
         exp_load  = pend_full && (!active || ((pos == cur_len - 1) && !bus.out_stall));

         chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
         chk("shift_en", 32'(bus.shift_en), 32'(exp_shift));
         if (exp_shift) chk("byte_out", 32'(bus.byte_out), 32'(bus.in_byte));
         chk("load_en", 32'(bus.load_en), 32'(exp_load));
         chk("out_valid", 32'(bus.out_valid), 32'(active));
         chk("k_size_6144", 32'(bus.k_size_6144), 32'(exp_k));
         if (active) begin
            chk("mux_ind", 32'(bus.mux_ind), 32'(pos));
            chk("out_first", 32'(bus.out_first), 32'(pos == 0));
            chk("out_last", 32'(bus.out_last), 32'(pos == cur_len - 1));
         end else begin
            chk("idle_first_last", 32'({bus.out_first, bus.out_last}), 32'(0));
         end
`ifdef INTLV_CTRL_DROP_DETECT_EN
         chk("drop_err", 32'(bus.drop_err), 32'(exp_drop));
         if (bus.in_valid && !exp_ready) exp_drop = 1'b1;
`endif
         if (active && !bus.out_stall) begin
            if (pos == cur_len - 1) begin
               active   = 1'b0;
               prev_end = cyc;
               pos      = 0;
            end else begin
               pos++;
            end
         end
      end
   end

   // Offers n bytes, holding each until accepted; a completed block is pushed to the scoreboard.
   task automatic send_bytes(input bit k, input int n, input bit gaps);
      int t;
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            bus.in_valid = 1'b0;
            @(posedge clock);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_byte  = 8'($urandom);
         bus.in_k6144 = (i == 0) ? k : 1'($urandom);
         t = -1;
         for (int w = 0; w < 20000; w++) begin
            @(negedge clock);
            if (bus.in_ready) begin
               t = cyc;
               break;
            end
         end
         if (t < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte %0d never accepted, required within 20000 cycles", i);
            bus.in_valid = 1'b0;
            return;
         end
         if ((i == n - 1) && (n == nbytes(k))) sb.push_back('{k: k, t_done: t});
         @(posedge clock);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (((sb.size() > 0) || active) && (w < 20000)) begin
         @(posedge clock);
         w++;
      end
      #1;
      n_tests++;
      if (w >= 20000) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d blocks still queued after 20000 cycles, required 0", sb.size());
      end
      chk("idle_after_drain", 32'(bus.out_valid), 32'(0));
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      int w;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
      bus.in_k6144 = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      rst = 1'b0;

      // single small block
      send_bytes(1'b0, 132, 1'b1);
      drain();

      // large block, then two small ones back to back; the third waits on a full buffer
      send_bytes(1'b1, 768, 1'b0);
      send_bytes(1'b0, 132, 1'b0);
      send_bytes(1'b0, 132, 1'b0);
`ifdef INTLV_CTRL_DROP_DETECT_EN
      chk("drop_err_set", 32'(bus.drop_err), 32'(1));
`endif
      drain();

      // stall at index 500, then at the last bit with a load pending
      stall_at    = 500;
      stall_armed = 1'b1;
      send_bytes(1'b0, 132, 1'b1);
      send_bytes(1'b0, 132, 1'b1);
      w = 0;
      while (stall_armed && (w < 5000)) begin
         @(posedge clock);
         w++;
      end
      #1;
      n_tests++;
      if (stall_armed) begin
         n_fail++;
         $display("FAIL stall_500_timeout: index 500 not reached, required within 5000 cycles");
      end
      stall_at    = 1055;
      stall_armed = 1'b1;
      w = 0;
      while (stall_armed && (w < 5000)) begin
         @(posedge clock);
         w++;
      end
      #1;
      stall_armed = 1'b0;
      rnd_stall   = 1'b1;
      drain();
      rnd_stall = 1'b0;

      // reset during a partial fill and mid-stream
      send_bytes(1'b1, 768, 1'b1);
      send_bytes(1'b1, 400, 1'b0);
      w = 0;
      while (!(bus.out_valid && (int'(bus.mux_ind) == 3000)) && (w < 10000)) begin
         @(posedge clock);
         #1;
         w++;
      end
      n_tests++;
      if (w >= 10000) begin
         n_fail++;
         $display("FAIL reach_3000_timeout: mux_ind %0d, required 3000", bus.mux_ind);
      end
      bus.in_valid = 1'b1;
      rst          = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("async_rst_mux_ind", 32'(bus.mux_ind), 32'(0));
      chk("async_rst_k_size", 32'(bus.k_size_6144), 32'(0));
      chk("async_rst_in_ready", 32'(bus.in_ready), 32'(0));
      chk("async_rst_shift_en", 32'(bus.shift_en), 32'(0));
      chk("async_rst_load_en", 32'(bus.load_en), 32'(0));
      repeat (3) @(posedge clock);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("post_rst_no_resume", 32'(bus.out_valid), 32'(0));
      send_bytes(1'b0, 132, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
